// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one external 4-bit combinational ALU between two requesters.
//   Arbitration is round-robin, and only one operation is in flight at a time.
//   Each response is registered and tagged with the ID of the requester that issued it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b     requester N (N = 0, 1) handshake and payload
//   alu_sel/alu_a/alu_b         registered operands driven to the ALU
//   alu_y/alu_carry             ALU result, captured at the end of EXEC
//   rsp_valid/ready/id/y/carry  response handshake and payload
//   busy                        high whenever the FSM is not in IDLE
//
// State | Meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; readies may assert, and a grant happens here
// EXEC  | ALU settles on the latched operands; its result is captured at the edge
// RESP  | response presented; held until rsp_ready

module alu_rr_scheduler #(
  parameter int DW  = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [OPW-1:0] alu_sel,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_carry,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_y,
  output logic           rsp_carry,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic           prio_q;
  logic [OPW-1:0] alu_sel_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [DW-1:0]  rsp_y_q;
  logic           rsp_carry_q;
  logic           busy_q;

  logic           idle;
  logic           any_valid;
  logic           gnt;

  assign idle      = (state_q == IDLE);
  assign any_valid = req0_valid | req1_valid;
  // When both requesters are valid, the priority bit decides the grant.
  // Otherwise the only valid requester wins. gnt has no effect when neither is valid.
  assign gnt       = (req0_valid & req1_valid) ? prio_q : req1_valid;

  assign req0_ready = idle & req0_valid & ~gnt;
  assign req1_ready = idle & req1_valid & gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            alu_sel_q <= gnt ? req1_op : req0_op;
            alu_a_q   <= gnt ? req1_a  : req0_a;
            alu_b_q   <= gnt ? req1_b  : req0_b;
            rsp_id_q  <= gnt;
            prio_q    <= ~gnt;
            busy_q    <= 1'b1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_carry_q <= alu_carry;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // The ALU operands are left unchanged after completion. The ALU simply sits on the last operation.
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a, req1_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b, alu_y;
  logic       alu_carry;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [3:0] rsp_y;

  int tests = 0;
  int fails = 0;
  logic [5:0] sb[$];   // {id, y, carry}

  always #5 clk = ~clk;

  alu_rr_scheduler #(.DW(4), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_carry(rsp_carry), .busy(busy)
  );

  // Reference ALU attached to the scheduler's ALU port
  logic [4:0] alu_r;
  always_comb begin
    alu_r = 5'd0;
    case (alu_sel)
      3'b000: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: alu_r = {1'b0, alu_a & alu_b};
      3'b011: alu_r = {1'b0, alu_a | alu_b};
      3'b100: alu_r = {1'b0, alu_a ^ alu_b};
      3'b101: alu_r = {1'b0, ~alu_a};
      3'b110: alu_r = {1'b0, alu_a + 4'd1};
      default: alu_r = {1'b0, alu_a - 4'd1};
    endcase
  end
  assign alu_y     = alu_r[3:0];
  assign alu_carry = alu_r[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected response per rsp handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp_payload", {26'd0, rsp_id, rsp_y, rsp_carry}, {26'd0, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    if (id == 1'b0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Raise valid and wait for ready at a negedge. On acceptance, push the
  // expected response and drop valid once the accepting edge has passed.
  task automatic issue(input logic id, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic push, input logic [5:0] e);
    bit got = 0;
    drive(id, 1'b1, op, a, b);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
    end
    check("accept_timeout", {31'd0, got}, 32'd1);
    if (got && push) sb.push_back(e);
    step();
    drive(id, 1'b0, op, a, b);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (!busy) done = 1;
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r_prev;
    int         ngnt;
    logic [3:0] order;
    bit         seen;

    rst_n = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);

    // 1: reset state
    #1;
    check("rst_outputs", {20'd0, rsp_valid, busy, rsp_id, rsp_carry, rsp_y, alu_sel, alu_a[0]},
          32'd0);
    check("rst_alu_ab", {24'd0, alu_a, alu_b}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_no_valid", {28'd0, busy, rsp_valid, req0_ready, req1_ready}, 32'd0);

    // 2: req0 ADD 9+8 -> y=1 carry=1, latency check
    issue(1'b0, 3'b000, 4'h9, 4'h8, 1'b1, {1'b0, 4'h1, 1'b1});
    check("exec_state", {29'd0, rsp_valid, busy, req0_ready}, {29'd0, 1'b0, 1'b1, 1'b0});
    check("alu_latched", {21'd0, alu_sel, alu_a, alu_b}, {21'd0, 3'b000, 4'h9, 4'h8});
    step();
    check("rsp_t2", {26'd0, rsp_valid, rsp_id, rsp_y, rsp_carry}, {26'd0, 1'b1, 1'b0, 4'h1, 1'b1});
    step();
    check("back_idle", {30'd0, busy, rsp_valid}, 32'd0);

    // 3: req1 SUB 3-5 -> E borrow, then XOR A^F -> 5
    issue(1'b1, 3'b001, 4'h3, 4'h5, 1'b1, {1'b1, 4'hE, 1'b1});
    wait_idle();
    issue(1'b1, 3'b100, 4'hA, 4'hF, 1'b1, {1'b1, 4'h5, 1'b0});
    wait_idle();

    // 4: both valid continuously from reset -> 0,1,0,1 with 1-cycle ready pulses
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 4'h1, 4'h2);   // 1+2 = 3
    drive(1'b1, 1'b1, 3'b010, 4'hF, 4'h6);   // F&6 = 6
    step(); step();
    rst_n = 1'b1;
    r_prev = 1'b0; ngnt = 0; order = 4'd0;
    for (int i = 0; i < 40 && ngnt < 4; i++) begin
      @(negedge clk);
      check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      check("ready_pulse", {31'd0, r_prev & (req0_ready | req1_ready)}, 32'd0);
      if (req0_ready | req1_ready) begin
        order[ngnt] = req1_ready;
        sb.push_back(req1_ready ? {1'b1, 4'h6, 1'b0} : {1'b0, 4'h3, 1'b0});
        ngnt++;
      end
      r_prev = req0_ready | req1_ready;
    end
    step();
    drive(1'b0, 1'b0, 3'b000, 4'h1, 4'h2);
    drive(1'b1, 1'b0, 3'b010, 4'hF, 4'h6);
    check("grant_count", ngnt, 32'd4);
    check("grant_order", {28'd0, order}, {28'd0, 4'b1010});
    wait_idle();

    // 5: rsp_ready low for 5 cycles during RESP
    rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 4'h5, 4'hA, 1'b1, {1'b0, 4'hF, 1'b0});
    drive(1'b1, 1'b1, 3'b101, 4'h3, 4'h0);   // ~3 = C, waits behind the stall
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (rsp_valid) seen = 1;
    end
    check("resp_timeout", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {24'd0, rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_y[3:1]},
            {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111});
      check("stall_y_c", {27'd0, rsp_y, rsp_carry}, {27'd0, 4'hF, 1'b0});
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("stall_release", {29'd0, busy, rsp_valid, req1_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
    sb.push_back({1'b1, 4'hC, 1'b0});
    step();
    drive(1'b1, 1'b0, 3'b101, 4'h3, 4'h0);
    wait_idle();

    // 6: reset during EXEC drops the op; req0 wins first afterwards
    issue(1'b0, 3'b000, 4'h1, 4'h1, 1'b0, 6'd0);
    rst_n = 1'b0;
    #1;
    check("rst_in_exec", {29'd0, busy, rsp_valid, alu_sel[0]}, 32'd0);
    drive(1'b0, 1'b1, 3'b110, 4'h7, 4'h0);   // 7+1 = 8
    drive(1'b1, 1'b1, 3'b111, 4'h0, 4'h0);   // 0-1 = F, carry 0
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_rsp_in_rst", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b10});
    if (req0_ready) sb.push_back({1'b0, 4'h8, 1'b0});
    step();
    drive(1'b0, 1'b0, 3'b110, 4'h7, 4'h0);
    issue(1'b1, 3'b111, 4'h0, 4'h0, 1'b1, {1'b1, 4'hF, 1'b0});
    wait_idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
